dmem_lsu: RTL and testbench

Parametrised, handshaked data-memory block for the RV32I pipeline's MEM stage. It replaces the fixed 1 KiB word-only memory with a configurable-depth, byte-addressed, little-endian store. It supports LB/LH/LW/LBU/LHU/SB/SH/SW with sign/zero extension, a configurable access latency, and error reporting for misaligned, out-of-range and illegal accesses. The pipeline stalls MEM on `req_ready`/`resp_valid`.

---
 rtl/dmem_pkg.sv | 42 ++++
 rtl/dmem_bytes.sv | 39 +++
 rtl/dmem_lsu.sv | 149 ++++++++++++++
 tb/tb_dmem_lsu.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared funct3 encodings, LSU state type and size/extend helpers
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [2:0] size_of(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   size_of = 3'd1;
      2'b01:   size_of = 3'd2;
      default: size_of = 3'd4;
    endcase
  endfunction

  // lane_data is already rotated so the addressed byte sits in bits [7:0]
  function automatic logic [31:0] extend(input logic [31:0] lane_data,
                                         input logic [2:0]  funct3);
    case (funct3)
      F3_B:    extend = {{24{lane_data[7]}}, lane_data[7:0]};
      F3_H:    extend = {{16{lane_data[15]}}, lane_data[15:0]};
      F3_BU:   extend = {24'd0, lane_data[7:0]};
      F3_HU:   extend = {16'd0, lane_data[15:0]};
      default: extend = lane_data;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_bytes.sv
`default_nettype none
// ============================================================================
// Module      : dmem_bytes
// Description : Four independent byte lanes, synchronous write, registered read
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_bytes #(
  parameter int DEPTH_BYTES = 1024,
  parameter int AW          = ((DEPTH_BYTES / 4) > 1) ? $clog2(DEPTH_BYTES / 4) : 1
) (
  input  logic                clk,
  input  logic                en,
  input  logic [3:0]          we,
  input  logic [3:0][AW-1:0]  idx,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata
);

  localparam int c_WORDS = DEPTH_BYTES / 4;

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] r_mem [c_WORDS];
    logic [7:0] r_q;

    // Read-before-write: a store never needs its own read data
    always_ff @(posedge clk) begin
      if (en) begin
        if (we[l]) begin
          r_mem[idx[l]] <= wdata[8*l +: 8];
        end
        r_q <= r_mem[idx[l]];
      end
    end

    assign rdata[8*l +: 8] = r_q;
  end

endmodule
`default_nettype wire

// File: rtl/dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : dmem_lsu
// Description : Handshaked byte-addressed RV32I data memory with fixed latency
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int c_AW = ((DEPTH_BYTES / 4) > 1) ? $clog2(DEPTH_BYTES / 4) : 1;
  localparam int c_CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t            r_state;
  state_t            w_next_state;
  logic [c_CW-1:0]   r_cnt;
  logic              r_we;
  logic [2:0]        r_f3;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic              r_err;

  logic              w_accept;
  logic              w_access;
  logic [2:0]        w_size;
  logic [1:0]        w_off;
  logic              w_illegal;
  logic              w_misaligned;
  logic              w_range;
  logic              w_err;
  logic [3:0]        w_mask;
  logic [3:0]        w_lane_we;
  logic [31:0]       w_wrot;
  logic [31:0]       w_ram_q;
  logic [31:0]       w_rrot;
  logic [3:0][c_AW-1:0] w_idx;

  always_comb begin
    w_next_state = r_state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next_state = WAIT;
      end
      WAIT: begin
        if (r_cnt == '0) w_next_state = RESP;
      end
      RESP: begin
        req_ready    = 1'b1;
        resp_valid   = 1'b1;
        w_next_state = req_valid ? WAIT : IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign w_accept = req_valid && req_ready;
  assign w_access = (r_state == WAIT) && (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_f3    <= 3'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_we    <= req_we;
        r_f3    <= req_funct3;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_cnt   <= c_CW'(LATENCY - 1);
      end else if ((r_state == WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_access) r_err <= w_err;
    end
  end

  // Error decode works on captured values, so it stays stable through RESP
  assign w_size       = size_of(r_f3);
  assign w_off        = r_addr[1:0];
  assign w_illegal    = r_we ? (r_f3[2] || (r_f3 == 3'b011))
                             : ((r_f3 == 3'b011) || (r_f3 == 3'b110) || (r_f3 == 3'b111));
  assign w_misaligned = ((w_size == 3'd2) && r_addr[0]) ||
                        ((w_size == 3'd4) && (w_off != 2'b00));
  assign w_range      = ({1'b0, r_addr} + {30'd0, w_size}) > 33'(DEPTH_BYTES);
  assign w_err        = w_illegal || w_misaligned || w_range;

  always_comb begin
    case (w_size)
      3'd1:    w_mask = 4'b0001;
      3'd2:    w_mask = 4'b0011;
      default: w_mask = 4'b1111;
    endcase
    w_mask    = w_mask << w_off;
    w_lane_we = (r_we && !w_err) ? w_mask : 4'b0000;
  end

  always_comb begin
    case (w_off)
      2'd0:    begin w_wrot = r_wdata;                        w_rrot = w_ram_q;                        end
      2'd1:    begin w_wrot = {r_wdata[23:0], r_wdata[31:24]}; w_rrot = {w_ram_q[7:0],  w_ram_q[31:8]};  end
      2'd2:    begin w_wrot = {r_wdata[15:0], r_wdata[31:16]}; w_rrot = {w_ram_q[15:0], w_ram_q[31:16]}; end
      default: begin w_wrot = {r_wdata[7:0],  r_wdata[31:8]};  w_rrot = {w_ram_q[23:0], w_ram_q[31:24]}; end
    endcase
  end

  // Accesses never straddle a word once alignment is enforced
  assign w_idx = {4{r_addr[c_AW+1:2]}};

  dmem_bytes #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .AW          (c_AW)
  ) u_bytes (
    .clk   (clk),
    .en    (w_access && !rst),
    .we    (w_lane_we),
    .idx   (w_idx),
    .wdata (w_wrot),
    .rdata (w_ram_q)
  );

  assign resp_err   = (r_state == RESP) && r_err;
  assign resp_rdata = ((r_state == RESP) && !r_we && !r_err) ? extend(w_rrot, r_f3) : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_lsu
// Description : Directed bench for dmem_lsu at LATENCY 1 and 3 with a byte-array model
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_lsu;

  localparam int DEPTH = 1024;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    int          due;
  } req_t;

  logic        clk;
  logic        rst;
  logic        vld    [2];
  logic        we_s   [2];
  logic [2:0]  f3_s   [2];
  logic [31:0] addr_s [2];
  logic [31:0] wd_s   [2];
  logic        rdy    [2];
  logic        rv     [2];
  logic [31:0] rd_o   [2];
  logic        err_o  [2];

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   armed  = 0;
  req_t q [2][$];
  logic [7:0] mdl [2][DEPTH];

  dmem_lsu #(.DEPTH_BYTES(DEPTH), .LATENCY(1)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(vld[0]), .req_ready(rdy[0]), .req_we(we_s[0]),
    .req_funct3(f3_s[0]), .req_addr(addr_s[0]), .req_wdata(wd_s[0]),
    .resp_valid(rv[0]), .resp_rdata(rd_o[0]), .resp_err(err_o[0]));

  dmem_lsu #(.DEPTH_BYTES(DEPTH), .LATENCY(3)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(vld[1]), .req_ready(rdy[1]), .req_we(we_s[1]),
    .req_funct3(f3_s[1]), .req_addr(addr_s[1]), .req_wdata(wd_s[1]),
    .resp_valid(rv[1]), .resp_rdata(rd_o[1]), .resp_err(err_o[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory semantics straight from the ISA: size, sign, alignment, range, legality.
  task automatic model_access(input int d, input req_t r, output logic [31:0] rd, output logic er);
    int     sz;
    bit     sgn;
    bit     ill;
    longint a;
    sz = 4; sgn = 0; ill = 0;
    case (r.f3)
      3'b000:  begin sz = 1; sgn = 1; end
      3'b001:  begin sz = 2; sgn = 1; end
      3'b010:  begin sz = 4; end
      3'b100:  begin sz = 1; ill = r.we; end
      3'b101:  begin sz = 2; ill = r.we; end
      default: ill = 1;
    endcase
    a  = longint'(r.addr);
    er = ill || ((a % sz) != 0) || ((a + sz) > DEPTH);
    rd = 32'd0;
    if (!er) begin
      for (int k = 0; k < sz; k++) begin
        if (r.we) mdl[d][int'(a) + k] = r.wd[8*k +: 8];
        else      rd[8*k +: 8] = mdl[d][int'(a) + k];
      end
      if (!r.we && sgn && sz == 1) rd = {{24{rd[7]}}, rd[7:0]};
      if (!r.we && sgn && sz == 2) rd = {{16{rd[15]}}, rd[15:0]};
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] erd;
    logic        eer;
    logic        erdy;
    req_t        nr;
    if (armed) begin
      for (int d = 0; d < 2; d++) begin
        erdy = (q[d].size() == 0) || (q[d][0].due == cyc);
        chk($sformatf("ready_d%0d", d), {31'd0, rdy[d]}, {31'd0, erdy});
        if (rv[d] === 1'b1) begin
          if (q[d].size() == 0 || q[d][0].due != cyc) begin
            chk($sformatf("unexpected_resp_d%0d", d), {31'd0, rv[d]}, 32'd0);
          end else begin
            model_access(d, q[d][0], erd, eer);
            void'(q[d].pop_front());
            chk($sformatf("model_rdata_d%0d", d), rd_o[d], erd);
            chk($sformatf("model_err_d%0d", d), {31'd0, err_o[d]}, {31'd0, eer});
          end
        end else if (q[d].size() != 0 && q[d][0].due == cyc) begin
          chk($sformatf("missing_resp_d%0d", d), {31'd0, rv[d]}, 32'd1);
          void'(q[d].pop_front());
        end
        if (rst) begin
          q[d].delete();
        end else if (vld[d] && rdy[d]) begin
          nr.we = we_s[d]; nr.f3 = f3_s[d]; nr.addr = addr_s[d]; nr.wd = wd_s[d];
          nr.due = cyc + 1 + lat(d);
          q[d].push_back(nr);
        end
      end
    end
  end

  task automatic wait_resp(input int d);
    int n;
    n = 0;
    @(negedge clk);
    while (rv[d] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic xact(input int d, input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] er, input logic ee, input string nm);
    int n;
    @(posedge clk); #1;
    vld[d] = 1'b1; we_s[d] = we; f3_s[d] = f3; addr_s[d] = a; wd_s[d] = wd;
    n = 0;
    @(negedge clk);
    while (rdy[d] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    vld[d] = 1'b0; we_s[d] = ~we; f3_s[d] = ~f3; addr_s[d] = ~a; wd_s[d] = ~wd;
    wait_resp(d);
    chk({nm, "_valid"}, {31'd0, rv[d]}, 32'd1);
    chk({nm, "_rdata"}, rd_o[d], er);
    chk({nm, "_err"}, {31'd0, err_o[d]}, {31'd0, ee});
  endtask

  task automatic b2b();
    int acc [3];
    int n;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      vld[1] = 1'b1;
      addr_s[1] = 32'h30;
      case (i)
        0:       begin we_s[1] = 1'b1; f3_s[1] = 3'b010; wd_s[1] = 32'hA5A5A5A5; end
        1:       begin we_s[1] = 1'b0; f3_s[1] = 3'b010; wd_s[1] = 32'd0; end
        default: begin we_s[1] = 1'b0; f3_s[1] = 3'b001; wd_s[1] = 32'd0; end
      endcase
      n = 0;
      @(negedge clk);
      while (rdy[1] !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      acc[i] = cyc + 1;
      @(posedge clk); #1;
    end
    vld[1] = 1'b0;
    chk("b2b_gap01", 32'(acc[1] - acc[0]), 32'd4);
    chk("b2b_gap12", 32'(acc[2] - acc[1]), 32'd4);
    wait_resp(1);
    chk("b2b_last_rdata", rd_o[1], 32'hFFFFA5A5);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      vld[d] = 1'b0; we_s[d] = 1'b0; f3_s[d] = 3'd0; addr_s[d] = 32'd0; wd_s[d] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_ready_d%0d", d), {31'd0, rdy[d]}, 32'd1);
      chk($sformatf("reset_valid_d%0d", d), {31'd0, rv[d]}, 32'd0);
      chk($sformatf("reset_rdata_d%0d", d), rd_o[d], 32'd0);
      chk($sformatf("reset_err_d%0d", d), {31'd0, err_o[d]}, 32'd0);
    end
    armed = 1;

    // LATENCY=1: lane, extension and partial-store behaviour
    xact(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        0, "sw_10");
    xact(0, 0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 0, "lw_10");
    xact(0, 0, 3'b000, 32'h13, 32'h0,        32'hFFFFFFDE, 0, "lb_13");
    xact(0, 0, 3'b100, 32'h13, 32'h0,        32'h000000DE, 0, "lbu_13");
    xact(0, 0, 3'b001, 32'h12, 32'h0,        32'hFFFFDEAD, 0, "lh_12");
    xact(0, 0, 3'b101, 32'h10, 32'h0,        32'h0000BEEF, 0, "lhu_10");
    xact(0, 1, 3'b000, 32'h11, 32'hAABBCC55, 32'h0,        0, "sb_11");
    xact(0, 0, 3'b010, 32'h10, 32'h0,        32'hDEAD55EF, 0, "lw_after_sb");
    xact(0, 1, 3'b001, 32'h12, 32'hFFFF1234, 32'h0,        0, "sh_12");
    xact(0, 0, 3'b010, 32'h10, 32'h0,        32'h123455EF, 0, "lw_after_sh");

    // Rejected accesses leave memory intact
    xact(0, 0, 3'b010, 32'h11,       32'h0,        32'h0, 1, "err_lw_mis");
    xact(0, 0, 3'b010, 32'h10,       32'h0,        32'h123455EF, 0, "chk1");
    xact(0, 1, 3'b001, 32'h13,       32'h0000FFFF, 32'h0, 1, "err_sh_mis");
    xact(0, 0, 3'b010, 32'h10,       32'h0,        32'h123455EF, 0, "chk2");
    xact(0, 0, 3'b010, DEPTH - 2,    32'h0,        32'h0, 1, "err_lw_range");
    xact(0, 0, 3'b010, 32'h10,       32'h0,        32'h123455EF, 0, "chk3");
    xact(0, 1, 3'b010, 32'hFFFFFFFC, 32'h0,        32'h0, 1, "err_sw_wrap");
    xact(0, 0, 3'b010, 32'h10,       32'h0,        32'h123455EF, 0, "chk4");
    xact(0, 0, 3'b011, 32'h10,       32'h0,        32'h0, 1, "err_ld_f3_011");
    xact(0, 1, 3'b100, 32'h10,       32'h0,        32'h0, 1, "err_st_f3_100");
    xact(0, 0, 3'b010, 32'h10,       32'h0,        32'h123455EF, 0, "chk5");
    xact(0, 1, 3'b000, DEPTH - 1,    32'h00000080, 32'h0, 0, "sb_last");
    xact(0, 0, 3'b000, DEPTH - 1,    32'h0,        32'hFFFFFF80, 0, "lb_last");
    xact(0, 0, 3'b100, DEPTH - 1,    32'h0,        32'h00000080, 0, "lbu_last");

    // LATENCY=3: throughput and reset abort
    xact(1, 1, 3'b010, 32'h20, 32'h11223344, 32'h0,        0, "l3_sw_20");
    xact(1, 0, 3'b010, 32'h20, 32'h0,        32'h11223344, 0, "l3_lw_20");
    b2b();

    @(posedge clk); #1;
    vld[1] = 1'b1; we_s[1] = 1'b1; f3_s[1] = 3'b010; addr_s[1] = 32'h20; wd_s[1] = 32'hCAFEF00D;
    @(posedge clk); #1;
    vld[1] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, rdy[1]}, 32'd1);
    chk("rst_valid", {31'd0, rv[1]}, 32'd0);
    chk("rst_rdata", rd_o[1], 32'd0);
    chk("rst_err", {31'd0, err_o[1]}, 32'd0);
    repeat (6) @(negedge clk);
    xact(1, 0, 3'b010, 32'h20, 32'h0, 32'h11223344, 0, "rst_lw_20");

    repeat (5) @(negedge clk);
    chk("drain_d0", 32'(q[0].size()), 32'd0);
    chk("drain_d1", 32'(q[1].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
